csa_resolve: RTL

// - Pipelined carry-propagate adder: the consumer of a carry-save tree's redundant output.
// - Takes the two carry-save operands (sum, carry) and resolves them into one binary word.
// - Carries ripple across CHUNK-bit segments, one segment per pipeline stage, with a valid/ready stream.
// - Sits between the accumulate carry-save tree and the modular-reduction stage of the NTT datapath.

---
 rtl/csa_resolve.sv | 109 ++++++++++
 1 files changed

// File: rtl/csa_resolve.sv
// Pipelined carry-propagate adder that turns a carry-save pair into one binary word.
// Each stage resolves one CHUNK-bit segment and hands its carry to the next stage.
// All stages share a single stall enable, so the pipe advances or holds as a whole.
module csa_resolve #(
    parameter int unsigned SIZE  = 36,
    parameter int unsigned CHUNK = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_sum,
    output logic            out_cout
);

    localparam int unsigned NSTG = (SIZE + CHUNK - 1) / CHUNK;
    localparam int unsigned W1   = SIZE + 1;

    // Lowest bit of segment j.
    function automatic int unsigned seg_lo(input int unsigned j);
        return j * CHUNK;
    endfunction

    // One past the highest bit of segment j; the last segment may be narrower.
    function automatic int unsigned seg_hi(input int unsigned j);
        return ((j * CHUNK + CHUNK) < SIZE) ? (j * CHUNK + CHUNK) : SIZE;
    endfunction

    // a_q[j]: result segments 0..j plus operand-a segments above j.
    logic [NSTG-1:0][SIZE-1:0] a_q, a_d;
    logic [NSTG-1:0]           c_q, c_d;
    logic [NSTG-1:0]           v_q, v_d;

    // Inputs seen by each stage: stage 0 from the ports, stage j from stage j-1.
    logic [NSTG-1:0][SIZE-1:0] pa, pb;
    logic [NSTG-1:0]           pc, pv;

    logic [NSTG-1:0][W1-1:0]   mask_c, full_c;
    logic                      en_c;

    // Single global stall enable; the only combinational handshake path.
    assign en_c     = !v_q[NSTG-1] || out_ready;
    assign in_ready = en_c;

    assign pa[0] = in_a;
    assign pb[0] = in_b;
    assign pc[0] = 1'b0;
    assign pv[0] = in_valid;

    if (NSTG > 1) begin : g_chain
        // Operand b is only needed until its last segment is consumed.
        logic [NSTG-2:0][SIZE-1:0] b_q;

        // Delay-line for the untouched b operand.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                b_q <= '0;
            end else if (en_c) begin
                b_q <= pb[NSTG-2:0];
            end
        end

        assign pa[NSTG-1:1] = a_q[NSTG-2:0];
        assign pb[NSTG-1:1] = b_q;
        assign pc[NSTG-1:1] = c_q[NSTG-2:0];
        assign pv[NSTG-1:1] = v_q[NSTG-2:0];
    end

    // Per-stage segment add: replace segment j of the word with a_j + b_j + c_j.
    always_comb begin
        a_d    = a_q;
        c_d    = c_q;
        v_d    = v_q;
        mask_c = '0;
        full_c = '0;
        for (int unsigned j = 0; j < NSTG; j++) begin
            mask_c[j] = (W1'(1) << seg_hi(j)) - (W1'(1) << seg_lo(j));
            full_c[j] = ({1'b0, pa[j]} & mask_c[j])
                      + ({1'b0, pb[j]} & mask_c[j])
                      + (W1'(pc[j]) << seg_lo(j));
            a_d[j]    = (pa[j] & ~(mask_c[j][SIZE-1:0]))
                      | (full_c[j][SIZE-1:0] & mask_c[j][SIZE-1:0]);
            c_d[j]    = |(full_c[j] & (W1'(1) << seg_hi(j)));
            v_d[j]    = pv[j];
        end
    end

    // Stage registers: clear on reset, advance together when enabled, else hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q <= '0;
            c_q <= '0;
            v_q <= '0;
        end else if (en_c) begin
            a_q <= a_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign out_valid = v_q[NSTG-1];
    assign out_sum   = a_q[NSTG-1];
    assign out_cout  = c_q[NSTG-1];

endmodule
